// File: rtl/debounce_multi.sv
// Multi-channel switch/button debouncer: per-channel synchroniser, stability
// counter gated by a sample qualifier, and registered rise/fall event pulses.
module debounce_multi #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   sync_out;
      logic                   state_reg;
      logic                   state_next;
      logic [CW-1:0]          cnt_reg;
      logic [CW-1:0]          cnt_next;
      logic                   rise_reg;
      logic                   fall_reg;

      assign sync_out = sync_reg[SYNC_STAGES-1];

      // A matching sample always clears the count; tick only gates progress.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (sync_out == state_reg) begin
          cnt_next = '0;
        end else if (tick) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = sync_out;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_reg  <= '0;
          state_reg <= 1'b0;
          cnt_reg   <= '0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          sync_reg  <= {sync_reg[SYNC_STAGES-2:0], sig[gi]};
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          // Pulses register on the same edge as the level so they line up.
          rise_reg  <= state_next & ~state_reg;
          fall_reg  <= ~state_next & state_reg;
        end
      end

      assign debounced[gi] = state_reg;
      assign rise[gi]      = rise_reg;
      assign fall[gi]      = fall_reg;
    end
  endgenerate

endmodule
